// File: rtl/iir_biquad_sequencer_pkg.sv
// Shared definitions for the time-multiplexed biquad sequencer:
// FSM state encoding, tap indices and the tap count.
package iir_biquad_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int NUM_TAPS = 5;

  localparam logic [2:0] TAP_B0 = 3'd0;
  localparam logic [2:0] TAP_B1 = 3'd1;
  localparam logic [2:0] TAP_B2 = 3'd2;
  localparam logic [2:0] TAP_A1 = 3'd3;
  localparam logic [2:0] TAP_A2 = 3'd4;

endpackage

// File: rtl/iir_biquad_sequencer_mac_sat.sv
// One multiply-accumulate step of a biquad tap, plus the output stage
// that rescales the running sum back to sample format with saturation.
// Purely combinational so a cascade can share or replicate it freely.
module iir_mac_sat
  import iir_biquad_sequencer_pkg::*;
#(
  parameter int bitwidth  = 32,
  parameter int frac_bits = 30
) (
  input  logic signed [bitwidth-1:0]   coef,
  input  logic signed [bitwidth-1:0]   operand,
  input  logic                         subtract,
  input  logic signed [2*bitwidth+2:0] acc,
  output logic signed [2*bitwidth+2:0] acc_next,
  output logic signed [bitwidth-1:0]   y_sat
);

  localparam int AW = 2 * bitwidth + 3;

  logic signed [2*bitwidth-1:0] product;
  logic signed [AW-1:0]         product_ext;
  logic signed [AW-1:0]         shifted;

  // Signed product, sign-extended and added to or subtracted from the sum
  always_comb begin
    product     = coef * operand;
    product_ext = {{3{product[2*bitwidth-1]}}, product};
    if (subtract) begin
      acc_next = acc - product_ext;
    end else begin
      acc_next = acc + product_ext;
    end
  end

  // Floor-shift out the coefficient fraction and clamp to the sample range
  always_comb begin
    shifted = acc_next >>> frac_bits;
    if ((&shifted[AW-1:bitwidth-1]) || (~|shifted[AW-1:bitwidth-1])) begin
      y_sat = shifted[bitwidth-1:0];
    end else if (shifted[AW-1]) begin
      y_sat = {1'b1, {(bitwidth-1){1'b0}}};
    end else begin
      y_sat = {1'b0, {(bitwidth-1){1'b1}}};
    end
  end

endmodule

// File: rtl/iir_biquad_sequencer.sv
// Order-2 IIR (biquad) controller: one shared multiplier is stepped over
// the five taps of each sample. Holds the coefficient bank, x/y history
// and the valid/ready handshakes on the input and output streams.
module iir_biquad_sequencer
  import iir_biquad_sequencer_pkg::*;
#(
  parameter int bitwidth  = 32,
  parameter int frac_bits = 30
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [bitwidth-1:0] x,
  input  logic                x_valid,
  output logic                x_ready,
  output logic [bitwidth-1:0] y,
  output logic                y_valid,
  input  logic                y_ready,
  input  logic                coef_we,
  input  logic [2:0]          coef_addr,
  input  logic [bitwidth-1:0] coef_wdata,
  input  logic                hist_clr,
  output logic                busy,
  output logic                coef_err
);

  localparam int AW = 2 * bitwidth + 3;
  localparam logic [bitwidth-1:0] UNITY = bitwidth'(1) << frac_bits;

  state_t                     state;
  logic [2:0]                 tap;
  logic signed [AW-1:0]       acc;
  logic signed [AW-1:0]       acc_next;
  logic signed [bitwidth-1:0] x0;
  logic signed [bitwidth-1:0] x1;
  logic signed [bitwidth-1:0] x2;
  logic signed [bitwidth-1:0] y1;
  logic signed [bitwidth-1:0] y2;
  logic signed [bitwidth-1:0] bank [NUM_TAPS];
  logic signed [bitwidth-1:0] tap_coef;
  logic signed [bitwidth-1:0] tap_operand;
  logic                       tap_subtract;
  logic signed [bitwidth-1:0] y_sat;
  logic                       coef_ok;

  assign busy    = (state != IDLE);
  assign x_ready = (state == IDLE) && rst_n;
  assign coef_ok = coef_we && (state == IDLE) && (coef_addr <= TAP_A2);

  // Select the coefficient/operand pair for the tap being accumulated
  always_comb begin
    tap_coef     = bank[0];
    tap_operand  = x0;
    tap_subtract = 1'b0;
    case (tap)
      TAP_B0: begin tap_coef = bank[0]; tap_operand = x0; end
      TAP_B1: begin tap_coef = bank[1]; tap_operand = x1; end
      TAP_B2: begin tap_coef = bank[2]; tap_operand = x2; end
      TAP_A1: begin tap_coef = bank[3]; tap_operand = y1; tap_subtract = 1'b1; end
      TAP_A2: begin tap_coef = bank[4]; tap_operand = y2; tap_subtract = 1'b1; end
      default: begin tap_coef = bank[0]; tap_operand = x0; end
    endcase
  end

  iir_mac_sat #(
    .bitwidth  (bitwidth),
    .frac_bits (frac_bits)
  ) u_mac_sat (
    .coef     (tap_coef),
    .operand  (tap_operand),
    .subtract (tap_subtract),
    .acc      (acc),
    .acc_next (acc_next),
    .y_sat    (y_sat)
  );

  // Coefficient bank: reset to pass-through, writable only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank[0] <= UNITY;
      for (int i = 1; i < NUM_TAPS; i++) begin
        bank[i] <= '0;
      end
    end else if (coef_ok) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        if (coef_addr == 3'(i)) begin
          bank[i] <= coef_wdata;
        end
      end
    end
  end

  // Flag for one cycle any write that the bank refused
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_err <= 1'b0;
    end else begin
      coef_err <= coef_we && !coef_ok;
    end
  end

  // Sample sequencer: accept, five MAC steps, hold result until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tap     <= '0;
      acc     <= '0;
      x0      <= '0;
      x1      <= '0;
      x2      <= '0;
      y1      <= '0;
      y2      <= '0;
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hist_clr) begin
            x1 <= '0;
            x2 <= '0;
            y1 <= '0;
            y2 <= '0;
          end
          if (x_valid) begin
            x0    <= x;
            acc   <= '0;
            tap   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          if (tap == TAP_A2) begin
            y       <= y_sat;
            y_valid <= 1'b1;
            x2      <= x1;
            x1      <= x0;
            y2      <= y1;
            y1      <= y_sat;
            tap     <= '0;
            state   <= OUT;
          end else begin
            tap <= tap + 3'd1;
          end
        end
        OUT: begin
          if (y_ready) begin
            y_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
